// File: rtl/control_fsm.sv
// Multi-cycle processor control unit: sequences FETCH/DECODE/EXEC/MEM/WB/IO_WAIT/HALT
// and drives the datapath strobes from the opcode latched during FETCH.
module control_fsm #(
  parameter int OP_W       = 6,
  parameter int ALUOP_W    = 5,
  parameter int IO_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               branch_flag,
  input  logic               io_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               RW,
  output logic               MW,
  output logic               RDst,
  output logic               ASrc,
  output logic               MTG,
  output logic               PSrc,
  output logic               Jmp,
  output logic               Jr,
  output logic               Jal,
  output logic               MO,
  output logic               out,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               io_req,
  output logic               halt,
  output logic               fault,
  output logic [2:0]         state
);

  localparam int CNT_W = $clog2(IO_TIMEOUT + 1);
  localparam int OPX_W = (OP_W > 6) ? OP_W : 6;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_IO_WAIT = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_HLT, C_ILL, C_IN, C_OUT, C_ALU,
    C_LW, C_SW, C_J, C_JR, C_BR, C_JAL
  } class_e;

  typedef struct packed {
    class_e     cls;
    logic [4:0] alu;
    logic       rdst;
    logic       asrc;
  } decode_t;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fault_q, fault_d;

  logic [OPX_W-1:0]  op_x;
  logic              op_hi;
  decode_t           dec;
  logic              hold_alu;

  // Opcode decode from the latched opcode; any bit above bit 5 makes it illegal.
  always_comb begin
    op_x  = OPX_W'(opcode_q);
    op_hi = (op_x >> 6) != '0;
    dec   = '{cls: C_ILL, alu: 5'b00000, rdst: 1'b0, asrc: 1'b0};
    if (!op_hi) begin
      case (op_x[5:0])
        6'h00: dec.cls = C_NOP;
        6'h3F: dec.cls = C_HLT;
        6'h1F: dec.cls = C_IN;
        6'h20: dec.cls = C_OUT;
        6'h02: dec = '{C_ALU, 5'b00000, 1'b1, 1'b0};
        6'h04: dec = '{C_ALU, 5'b00001, 1'b1, 1'b0};
        6'h06: dec = '{C_ALU, 5'b00010, 1'b1, 1'b0};
        6'h07: dec = '{C_ALU, 5'b00011, 1'b1, 1'b0};
        6'h08: dec = '{C_ALU, 5'b01010, 1'b1, 1'b0};
        6'h10: dec = '{C_ALU, 5'b00111, 1'b1, 1'b0};
        6'h11: dec = '{C_ALU, 5'b00101, 1'b1, 1'b0};
        6'h12: dec = '{C_ALU, 5'b00110, 1'b1, 1'b0};
        6'h03: dec = '{C_ALU, 5'b00000, 1'b0, 1'b1};
        6'h05: dec = '{C_ALU, 5'b00001, 1'b0, 1'b1};
        6'h14: dec = '{C_ALU, 5'b00111, 1'b0, 1'b1};
        6'h15: dec = '{C_ALU, 5'b00101, 1'b0, 1'b1};
        6'h16: dec = '{C_ALU, 5'b00110, 1'b0, 1'b1};
        6'h0C: dec = '{C_ALU, 5'b00000, 1'b0, 1'b1};
        6'h09: dec = '{C_ALU, 5'b01001, 1'b0, 1'b0};
        6'h0A: dec = '{C_ALU, 5'b01000, 1'b0, 1'b0};
        6'h13: dec = '{C_ALU, 5'b00100, 1'b0, 1'b0};
        6'h0B: dec = '{C_LW,  5'b00000, 1'b0, 1'b1};
        6'h0D: dec = '{C_SW,  5'b00000, 1'b0, 1'b1};
        6'h0E: dec.cls = C_J;
        6'h0F: dec.cls = C_JR;
        6'h21: dec.cls = C_JAL;
        // Branch pairs: register compare and its compare-with-zero twin share an ALUop.
        6'h17, 6'h1B: dec = '{C_BR, 5'b01111, 1'b0, 1'b0};
        6'h18, 6'h1C: dec = '{C_BR, 5'b01100, 1'b0, 1'b0};
        6'h19, 6'h1D: dec = '{C_BR, 5'b01010, 1'b0, 1'b0};
        6'h1A, 6'h1E: dec = '{C_BR, 5'b01011, 1'b0, 1'b0};
        default: dec.cls = C_ILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q  <= state_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    state_d  = state_q;
    opcode_d = opcode_q;
    count_d  = count_q;
    fault_d  = fault_q;
    pc_write = 1'b0;
    ir_write = 1'b0;
    RW       = 1'b0;
    MW       = 1'b0;
    MTG      = 1'b0;
    PSrc     = 1'b0;
    Jmp      = 1'b0;
    Jr       = 1'b0;
    Jal      = 1'b0;
    MO       = 1'b0;
    out      = 1'b0;
    io_req   = 1'b0;
    halt     = 1'b0;
    hold_alu = 1'b0;

    // Outputs are gated by rst_n so strobes drop the instant reset asserts.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          opcode_d = opcode;
          state_d  = S_DECODE;
        end
        S_DECODE: begin
          count_d = '0;
          case (dec.cls)
            C_NOP:        state_d = S_FETCH;
            C_HLT:        state_d = S_HALT;
            C_IN, C_OUT:  state_d = S_IO_WAIT;
            C_ILL: begin
              state_d = S_HALT;
              fault_d = 1'b1;
            end
            default:      state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          hold_alu = 1'b1;
          case (dec.cls)
            C_ALU:       state_d = S_WB;
            C_LW, C_SW:  state_d = S_MEM;
            C_J: begin
              Jmp      = 1'b1;
              pc_write = 1'b1;
              state_d  = S_FETCH;
            end
            C_JR: begin
              Jr       = 1'b1;
              pc_write = 1'b1;
              state_d  = S_FETCH;
            end
            C_BR: begin
              PSrc     = 1'b1;
              pc_write = branch_flag;
              state_d  = S_FETCH;
            end
            C_JAL: begin
              Jal      = 1'b1;
              pc_write = 1'b1;
              state_d  = S_WB;
            end
            default: begin
              state_d = S_HALT;
              fault_d = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          hold_alu = 1'b1;
          case (dec.cls)
            C_SW: begin
              MW      = 1'b1;
              state_d = S_FETCH;
            end
            C_LW: begin
              MTG     = 1'b1;
              state_d = S_WB;
            end
            default: begin
              state_d = S_HALT;
              fault_d = 1'b1;
            end
          endcase
        end
        S_WB: begin
          hold_alu = 1'b1;
          RW       = 1'b1;
          MTG      = (dec.cls == C_LW);
          MO       = (dec.cls == C_IN);
          Jal      = (dec.cls == C_JAL);
          state_d  = S_FETCH;
        end
        S_IO_WAIT: begin
          io_req = 1'b1;
          MO     = (dec.cls == C_IN);
          out    = (dec.cls == C_OUT);
          // A ready in the final allowed cycle still completes the transfer.
          if (io_ready) begin
            state_d = (dec.cls == C_IN) ? S_WB : S_FETCH;
          end else if (count_q == CNT_W'(IO_TIMEOUT - 1)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        S_HALT: halt = 1'b1;
        default: begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end
      endcase
    end
  end

  assign ALUop = hold_alu ? ALUOP_W'(dec.alu) : '0;
  assign RDst  = hold_alu & dec.rdst;
  assign ASrc  = hold_alu & dec.asrc;
  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: a per-instruction trace model built from the
// opcode classes and cycle rules, compared cycle by cycle against the DUT outputs.
module tb_control_fsm;

  localparam int OP_W       = 8;
  localparam int ALUOP_W    = 5;
  localparam int IO_TIMEOUT = 255;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [OP_W-1:0]    opcode = '0;
  logic               branch_flag = 1'b0;
  logic               io_ready = 1'b0;
  logic               pc_write, ir_write, RW, MW, RDst, ASrc, MTG, PSrc;
  logic               Jmp, Jr, Jal, MO, out, io_req, halt, fault;
  logic [ALUOP_W-1:0] ALUop;
  logic [2:0]         state;

  control_fsm #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .IO_TIMEOUT(IO_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_flag(branch_flag),
    .io_ready(io_ready), .pc_write(pc_write), .ir_write(ir_write), .RW(RW),
    .MW(MW), .RDst(RDst), .ASrc(ASrc), .MTG(MTG), .PSrc(PSrc), .Jmp(Jmp),
    .Jr(Jr), .Jal(Jal), .MO(MO), .out(out), .ALUop(ALUop), .io_req(io_req),
    .halt(halt), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic halt, fault, io_req, pcw, irw, rw, mw, rdst, asrc;
    logic mtg, psrc, jmp, jr, jal, mo, outp;
    logic [4:0] aluop;
  } ctl_t;

  typedef struct packed {
    logic [7:0] op;
    logic       bf;
    logic       rdy;
    ctl_t       exp;
  } step_t;

  step_t steps[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic ctl_t observed();
    ctl_t o;
    o.st = state;     o.halt = halt;  o.fault = fault; o.io_req = io_req;
    o.pcw = pc_write; o.irw = ir_write; o.rw = RW;     o.mw = MW;
    o.rdst = RDst;    o.asrc = ASrc;  o.mtg = MTG;     o.psrc = PSrc;
    o.jmp = Jmp;      o.jr = Jr;      o.jal = Jal;     o.mo = MO;
    o.outp = out;     o.aluop = ALUop;
    return o;
  endfunction

  // Instruction set table: class name, ALU operation, register-destination and immediate flags.
  function automatic void classify(input logic [7:0] op, output string cls,
                                   output logic [4:0] alu, output logic rdst, output logic asrc);
    cls = "ill"; alu = 5'd0; rdst = 1'b0; asrc = 1'b0;
    case (op)
      8'h00: cls = "nop";
      8'h3F: cls = "hlt";
      8'h1F: cls = "in";
      8'h20: cls = "out";
      8'h02: begin cls = "alu"; alu = 5'b00000; rdst = 1'b1; end
      8'h04: begin cls = "alu"; alu = 5'b00001; rdst = 1'b1; end
      8'h06: begin cls = "alu"; alu = 5'b00010; rdst = 1'b1; end
      8'h07: begin cls = "alu"; alu = 5'b00011; rdst = 1'b1; end
      8'h08: begin cls = "alu"; alu = 5'b01010; rdst = 1'b1; end
      8'h10: begin cls = "alu"; alu = 5'b00111; rdst = 1'b1; end
      8'h11: begin cls = "alu"; alu = 5'b00101; rdst = 1'b1; end
      8'h12: begin cls = "alu"; alu = 5'b00110; rdst = 1'b1; end
      8'h03: begin cls = "alu"; alu = 5'b00000; asrc = 1'b1; end
      8'h05: begin cls = "alu"; alu = 5'b00001; asrc = 1'b1; end
      8'h14: begin cls = "alu"; alu = 5'b00111; asrc = 1'b1; end
      8'h15: begin cls = "alu"; alu = 5'b00101; asrc = 1'b1; end
      8'h16: begin cls = "alu"; alu = 5'b00110; asrc = 1'b1; end
      8'h0C: begin cls = "alu"; alu = 5'b00000; asrc = 1'b1; end
      8'h09: begin cls = "alu"; alu = 5'b01001; end
      8'h0A: begin cls = "alu"; alu = 5'b01000; end
      8'h13: begin cls = "alu"; alu = 5'b00100; end
      8'h0B: begin cls = "lw";  asrc = 1'b1; end
      8'h0D: begin cls = "sw";  asrc = 1'b1; end
      8'h0E: cls = "j";
      8'h0F: cls = "jr";
      8'h21: cls = "jal";
      8'h17, 8'h1B: begin cls = "br"; alu = 5'b01111; end
      8'h18, 8'h1C: begin cls = "br"; alu = 5'b01100; end
      8'h19, 8'h1D: begin cls = "br"; alu = 5'b01010; end
      8'h1A, 8'h1E: begin cls = "br"; alu = 5'b01011; end
      default: cls = "ill";
    endcase
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [7:0] op, input logic bf, input logic rdy, input ctl_t e);
    step_t s;
    s.op = op; s.bf = bf; s.rdy = rdy; s.exp = e;
    steps.push_back(s);
  endfunction

  // Appends the expected cycle trace of one instruction; returns 1 if it ends in HALT.
  // io_delay = idle IO_WAIT cycles before io_ready; io_delay >= IO_TIMEOUT means never ready.
  function automatic bit build(input logic [7:0] op, input logic bf, input int io_delay);
    string cls;
    logic [4:0] alu;
    logic rdst, asrc;
    ctl_t e, x;
    int n;
    bit never;
    classify(op, cls, alu, rdst, asrc);
    e = '0; e.irw = 1'b1; e.pcw = 1'b1;
    push(op, rb(), rb(), e);
    e = '0; e.st = 3'd1;
    push(8'($urandom), rb(), rb(), e);
    x = '0; x.aluop = alu; x.rdst = rdst; x.asrc = asrc;
    if (cls == "nop") return 1'b0;
    if (cls == "hlt" || cls == "ill") begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.st = 3'd6; e.halt = 1'b1; e.fault = (cls == "ill");
        push(8'($urandom), rb(), rb(), e);
      end
      return 1'b1;
    end
    if (cls == "in" || cls == "out") begin
      never = (io_delay >= IO_TIMEOUT);
      n = never ? IO_TIMEOUT : io_delay + 1;
      for (int k = 1; k <= n; k++) begin
        e = '0; e.st = 3'd5; e.io_req = 1'b1; e.mo = (cls == "in"); e.outp = (cls == "out");
        push(8'($urandom), rb(), !never && (k == n), e);
      end
      if (never) begin
        for (int i = 0; i < 3; i++) begin
          e = '0; e.st = 3'd6; e.halt = 1'b1; e.fault = 1'b1;
          push(8'($urandom), rb(), 1'b0, e);
        end
        return 1'b1;
      end
      if (cls == "in") begin
        e = '0; e.st = 3'd4; e.rw = 1'b1; e.mo = 1'b1;
        push(8'($urandom), rb(), rb(), e);
      end
      return 1'b0;
    end
    e = x; e.st = 3'd2;
    if (cls == "j")   begin e.jmp = 1'b1; e.pcw = 1'b1; end
    if (cls == "jr")  begin e.jr = 1'b1;  e.pcw = 1'b1; end
    if (cls == "jal") begin e.jal = 1'b1; e.pcw = 1'b1; end
    if (cls == "br")  begin e.psrc = 1'b1; e.pcw = bf; end
    push(8'($urandom), bf, rb(), e);
    if (cls == "lw" || cls == "sw") begin
      e = x; e.st = 3'd3; e.mtg = (cls == "lw"); e.mw = (cls == "sw");
      push(8'($urandom), rb(), rb(), e);
    end
    if (cls == "alu" || cls == "lw" || cls == "jal") begin
      e = x; e.st = 3'd4; e.rw = 1'b1; e.mtg = (cls == "lw"); e.jal = (cls == "jal");
      push(8'($urandom), rb(), rb(), e);
    end
    return 1'b0;
  endfunction

  // Plays queued steps: inputs driven 1 unit after posedge, outputs sampled at negedge.
  task automatic apply_steps(input string name, input int max_steps);
    step_t s;
    ctl_t got;
    int idx;
    idx = 0;
    while (steps.size() > 0 && idx < max_steps) begin
      s = steps.pop_front();
      opcode = OP_W'(s.op); branch_flag = s.bf; io_ready = s.rdy;
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL %s op=%h cyc %0d: got st=%0d ctl=%b, want st=%0d ctl=%b",
                 name, s.op, idx, got.st, got, s.exp.st, s.exp);
      end
      @(posedge clk); #1;
      idx++;
    end
    steps.delete();
  endtask

  task automatic run_op(input string name, input logic [7:0] op, input logic bf, input int io_delay);
    bit halted;
    halted = build(op, bf, io_delay);
    apply_steps(name, 1 << 30);
    if (halted) do_reset(name);
  endtask

  task automatic check_zero(input string name);
    ctl_t got;
    got = observed();
    vectors++;
    if (got !== ctl_t'(0)) begin
      miscompares++;
      $display("FAIL %s: got st=%0d ctl=%b, want all zero", name, got.st, got);
    end
  endtask

  // Asynchronous reset between clock edges; released 1 unit after a posedge.
  task automatic do_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check_zero({name, "_reset"});
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1 check_zero("reset_t0");
    for (int i = 0; i < 3; i++) begin
      opcode = OP_W'($urandom); branch_flag = rb(); io_ready = rb();
      @(negedge clk);
      check_zero("reset_held");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    run_op("add", 8'h02, 1'b0, 0);
    run_op("shl", 8'h0A, 1'b1, 0);
    run_op("ori", 8'h16, 1'b0, 0);
    run_op("nop", 8'h00, 1'b0, 0);
  endtask

  task automatic test_mem();
    run_op("lw", 8'h0B, 1'b0, 0);
    run_op("sw", 8'h0D, 1'b1, 0);
  endtask

  task automatic test_branch();
    run_op("beq_taken", 8'h17, 1'b1, 0);
    run_op("beq_not", 8'h17, 1'b0, 0);
    run_op("bltz_taken", 8'h1E, 1'b1, 0);
    run_op("j", 8'h0E, 1'b0, 0);
    run_op("jr", 8'h0F, 1'b1, 0);
    run_op("jal", 8'h21, 1'b0, 0);
  endtask

  task automatic test_io();
    run_op("in_wait3", 8'h1F, 1'b0, 3);
    run_op("out_wait0", 8'h20, 1'b0, 0);
    run_op("in_last_cycle", 8'h1F, 1'b0, IO_TIMEOUT - 1);
    run_op("in_timeout", 8'h1F, 1'b0, IO_TIMEOUT);
    run_op("out_timeout", 8'h20, 1'b0, IO_TIMEOUT);
  endtask

  task automatic test_halt();
    run_op("hlt", 8'h3F, 1'b0, 0);
    run_op("illegal_25", 8'h25, 1'b0, 0);
    run_op("illegal_01", 8'h01, 1'b1, 0);
    run_op("illegal_hibit", 8'h42, 1'b0, 0);
  endtask

  task automatic test_reset_mid_exec();
    bit halted;
    halted = build(8'h02, 1'b0, 0);
    apply_steps("mid_exec_pre", 2);
    #1 rst_n = 1'b0;
    #1 check_zero("mid_exec_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("mid_exec_after", 8'h04, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] op;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 29) == 0)
        op = ($urandom_range(0, 1) == 1) ? 8'h3F : 8'($urandom_range(8'h22, 8'hFF));
      else begin
        op = 8'($urandom_range(0, 8'h21));
        if (op == 8'h01) op = 8'h02;
      end
      run_op("random", op, rb(), $urandom_range(0, 6));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_io();
    test_halt();
    test_reset_mid_exec();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
